dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 The block SHALL have parameter TRIGGER_ADDR, default 16'h4014, the CPU write address that starts a transfer.
REQ-002 The block SHALL have parameter DST_ADDR, default 16'h2004, the fixed destination address for every DMA write.
REQ-003 The block SHALL have port clk_in, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port cpu_address, input, 16 bits, the CPU address_out.
REQ-006 The block SHALL have port cpu_data_out, input, 8 bits, the CPU data_out.
REQ-007 The block SHALL have port cpu_read_write, input, 1 bit, the CPU READ_write (1 = write).
REQ-008 The block SHALL have port cpu_rdy, output, 1 bit; 0 = CPU clock-enable withheld (stall).
REQ-009 The block SHALL have port mem_data_in, input, 8 bits, the memory read data.
REQ-010 The block SHALL have port mem_address, output, 16 bits, the memory address.
REQ-011 The block SHALL have port mem_data_out, output, 8 bits, the memory write data.
REQ-012 The block SHALL have port mem_read_write, output, 1 bit, the memory strobe (1 = write).
REQ-013 The block SHALL have port dma_busy, output, 1 bit, high whenever the state is not IDLE.
REQ-014 The block SHALL have port dma_done, output, 1 bit, a one-cycle pulse on completion.

Function
REQ-015 The block SHALL implement states IDLE, HALT, ALIGN, READ, WRITE and DONE.
REQ-016 A trigger SHALL be a cycle in IDLE with cpu_read_write=1 and cpu_address=TRIGGER_ADDR; at that edge it latches page<=cpu_data_out and idx<=0 and moves IDLE->HALT.
REQ-017 In IDLE and DONE, cpu_rdy SHALL be 1 and mem_address, mem_data_out and mem_read_write SHALL equal the CPU signals combinationally, so the trigger write itself reaches memory.
REQ-018 In HALT, ALIGN, READ and WRITE, cpu_rdy SHALL be 0 and the memory bus SHALL be driven only by the block.
REQ-019 HALT SHALL hold for one cycle, then go to ALIGN if configured per REQ-030, else to READ; in HALT and ALIGN the outputs SHALL be mem_read_write=0 and mem_address={page,idx}.
REQ-020 In READ the outputs SHALL be mem_address={page,idx} and mem_read_write=0; the block SHALL latch mem_data_in at the closing edge and go to WRITE.
REQ-021 In WRITE the outputs SHALL be mem_address=DST_ADDR, mem_read_write=1 and mem_data_out=the latched byte; at the closing edge idx increments modulo 256.
REQ-022 After WRITE, the next state SHALL be DONE if idx was 8'hFF (wrap to 0), else READ; exactly 256 read/write pairs occur.
REQ-023 DONE SHALL last one cycle with dma_done=1 and dma_busy=1, then go to IDLE.
REQ-024 dma_done SHALL be 0 in all other states.
REQ-025 A trigger SHALL be recognised only in IDLE; a trigger-matching CPU cycle during DONE SHALL pass through to memory but SHALL NOT restart the transfer.
REQ-026 Base stall length SHALL be 513 cycles (HALT + 512).
REQ-027 A page of 8'hFF SHALL read FF00-FFFF, and the address SHALL NOT carry into the high byte.

Reset
REQ-028 While reset=0, the block SHALL hold state=IDLE, page=0, idx=0, data latch=0, parity=0, cpu_rdy=1, dma_busy=0 and dma_done=0.
REQ-029 Reset asserted mid-transfer SHALL abort immediately, with no dma_done pulse and no further DMA write; after release the block SHALL be in IDLE with the bus given to the CPU.

Configuration
REQ-030 With macro DMA_ODD_ALIGN_EN defined, a parity flop SHALL toggle every cycle from 0 after reset, and HALT SHALL go to ALIGN (one extra stall cycle, 514 total) when parity=1 in the HALT cycle, else to READ.
REQ-031 Without DMA_ODD_ALIGN_EN, the parity flop and ALIGN state SHALL be absent and HALT SHALL always go to READ (513 cycles).

Structure
REQ-032 Package dma_states SHALL hold dma_state_t enum and the DMA_TRANSFER_LEN=256 constant.
REQ-033 The page and data latches SHALL instantiate the existing register module (load, inc tied 0, reset driven by the inverted active-low reset).
REQ-034 The FSM, idx counter and bus mux SHALL live in dma_controller, and no other sub-module is needed.

Verification
REQ-035 Idle pass-through: CPU write A5 to 0200 -> mem_address=0200, mem_data_out=A5, mem_read_write=1, cpu_rdy=1, dma_busy=0.
REQ-036 Full copy, page 02 preloaded with 00..FF: CPU writes 02 to 4014 -> 256 writes to 2004 with data 00..FF in order, cpu_rdy low 513 cycles, one dma_done pulse.
REQ-037 Page FF: CPU writes FF to 4014 -> reads FF00..FFFF, never 0000.
REQ-038 Reset mid-transfer: assert reset after 100 writes -> cpu_rdy=1 asynchronously, no dma_done, no further 2004 writes; a new trigger afterward restarts at idx 0.
REQ-039 DMA_ODD_ALIGN_EN defined: trigger at parity 0 -> 513-cycle stall; at parity 1 -> 514-cycle stall; otherwise identical data sequence.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared state encoding and transfer constants for dma_controller.
// ALIGN exists only when DMA_ODD_ALIGN_EN is defined.
package dma_states;

    localparam int         DMA_TRANSFER_LEN = 256;
    localparam logic [7:0] DMA_LAST_IDX     = 8'(DMA_TRANSFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
`ifdef DMA_ODD_ALIGN_EN
        ALIGN = 3'd2,
`endif
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    // The CPU keeps its clock enable and the memory bus in these states only.
    function automatic logic cpu_owns_bus(input dma_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/dma_controller_register.sv
// Generic loadable/incrementable register with asynchronous active-high reset.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Load has priority over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end else if (inc_i) begin
            q_q <= q_q + WIDTH'(1);
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dma_controller.sv
// Page-copy DMA: stalls the CPU and copies 256 bytes from {page,idx} to DST_ADDR.
// Optional DMA_ODD_ALIGN_EN adds an ALIGN stall cycle when the parity flop is odd.
module dma_controller
    import dma_states::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR     = 16'h2004
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read_write,
    output logic        cpu_rdy,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic        mem_read_write,
    output logic        dma_busy,
    output logic        dma_done
);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_s, data_s;
    logic       trigger_s, rst_s;
    logic       cpu_rdy_q, dma_busy_q, dma_done_q;

    assign rst_s     = ~reset;
    assign trigger_s = (state_q == IDLE) && cpu_read_write && (cpu_address == TRIGGER_ADDR);

    register #(.WIDTH(8)) u_page_reg (
        .clk_i (clk_in),
        .rst_i (rst_s),
        .load_i(trigger_s),
        .inc_i (1'b0),
        .d_i   (cpu_data_out),
        .q_o   (page_s)
    );

    register #(.WIDTH(8)) u_data_reg (
        .clk_i (clk_in),
        .rst_i (rst_s),
        .load_i(state_q == READ),
        .inc_i (1'b0),
        .d_i   (mem_data_in),
        .q_o   (data_s)
    );

`ifdef DMA_ODD_ALIGN_EN
    logic parity_q;

    // Free-running cycle parity used to decide whether ALIGN is inserted.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end
`endif

    // Next-state and index logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    state_d = HALT;
                    idx_d   = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
`ifdef DMA_ODD_ALIGN_EN
                if (parity_q) begin
                    state_d = ALIGN;
                end else begin
                    state_d = READ;
                end
`else
                state_d = READ;
`endif
            end
`ifdef DMA_ODD_ALIGN_EN
            ALIGN: state_d = READ;
`endif
            READ:  state_d = WRITE;
            WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == DMA_LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: begin
                state_d = IDLE;
                idx_d   = 8'h00;
            end
        endcase
    end

    // State, index and status outputs, registered from the next state.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= 8'h00;
            cpu_rdy_q  <= 1'b1;
            dma_busy_q <= 1'b0;
            dma_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cpu_rdy_q  <= cpu_owns_bus(state_d);
            dma_busy_q <= (state_d != IDLE);
            dma_done_q <= (state_d == DONE);
        end
    end

    // Memory bus mux: CPU passes straight through in IDLE/DONE so the trigger write lands.
    always_comb begin
        mem_address    = cpu_address;
        mem_data_out   = cpu_data_out;
        mem_read_write = cpu_read_write;
        case (state_q)
            IDLE, DONE: begin
                mem_address    = cpu_address;
                mem_data_out   = cpu_data_out;
                mem_read_write = cpu_read_write;
            end
            WRITE: begin
                mem_address    = DST_ADDR;
                mem_data_out   = data_s;
                mem_read_write = 1'b1;
            end
            default: begin
                mem_address    = {page_s, idx_q};
                mem_data_out   = data_s;
                mem_read_write = 1'b0;
            end
        endcase
    end

    assign cpu_rdy  = cpu_rdy_q;
    assign dma_busy = dma_busy_q;
    assign dma_done = dma_done_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: idle pass-through table plus full-copy, page FF,
// DONE re-trigger and mid-transfer reset sequences against a behavioural memory.
module tb_dma_controller;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DST  = 16'h2004;
`ifdef DMA_ODD_ALIGN_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_read_write;
    logic        cpu_rdy;
    logic [7:0]  mem_data_in;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out;
    logic        mem_read_write;
    logic        dma_busy;
    logic        dma_done;

    logic [7:0] mem [0:65535];
    logic       par_model;
    int         n_checks = 0;
    int         n_pass   = 0;

    dma_controller #(.TRIGGER_ADDR(TRIG), .DST_ADDR(DST)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .cpu_address   (cpu_address),
        .cpu_data_out  (cpu_data_out),
        .cpu_read_write(cpu_read_write),
        .cpu_rdy       (cpu_rdy),
        .mem_data_in   (mem_data_in),
        .mem_address   (mem_address),
        .mem_data_out  (mem_data_out),
        .mem_read_write(mem_read_write),
        .dma_busy      (dma_busy),
        .dma_done      (dma_done)
    );

    always #5 clk_in = ~clk_in;

    assign mem_data_in = mem[mem_address];

    always @(posedge clk_in) begin
        if (mem_read_write) mem[mem_address] <= mem_data_out;
    end

    always @(posedge clk_in or negedge reset) begin
        if (!reset) par_model <= 1'b0;
        else        par_model <= ~par_model;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] pg, input int i);
        logic [7:0] b;
        b = 8'(i);
        return (pg == 8'hFF) ? ~b : b;
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_rw;
        logic        e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_parity(input logic want);
        for (int k = 0; k < 4 && par_model !== want; k++) @(negedge clk_in);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE (or with reset held low on abort).
    task automatic run_transfer(input logic [7:0] pg, input bit retrig, input int abort_after);
        int  stall, writes, dones, exp_stall;
        bit  halt_par, finished, bad_addr, pending;
        stall = 0; writes = 0; dones = 0; finished = 0; bad_addr = 0; pending = 0; halt_par = 0;
        cpu_address = TRIG; cpu_data_out = pg; cpu_read_write = 1'b1;
        #1;
        check("trigger_passthru", {mem_address, mem_data_out, mem_read_write, cpu_rdy},
              {TRIG, pg, 1'b1, 1'b1});
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_in);
            if (pending || c == 0) begin
                cpu_address = 16'h0000; cpu_data_out = 8'h00; cpu_read_write = 1'b0;
                pending = 0;
            end
            #1;
            if (c == 0) halt_par = par_model;
            if (!cpu_rdy) stall++;
            if (!cpu_rdy && mem_read_write && mem_address == DST) begin
                check("write_data", {24'h0, mem_data_out}, {24'h0, exp_byte(pg, writes)});
                writes++;
            end
            if (!cpu_rdy && !mem_read_write && mem_address[15:8] != pg) bad_addr = 1;
            if (dma_done) begin
                dones++;
                check("done_busy", {cpu_rdy, dma_busy}, {1'b1, 1'b1});
                if (retrig) begin
                    cpu_address = TRIG; cpu_data_out = 8'h77; cpu_read_write = 1'b1;
                    #1;
                    check("done_passthru", {mem_address, mem_data_out, mem_read_write},
                          {TRIG, 8'h77, 1'b1});
                    pending = 1;
                end
            end else if (dones > 0 && !dma_busy) begin
                finished = 1;
                break;
            end
            if (abort_after > 0 && writes == abort_after) begin
                @(negedge clk_in);
                reset = 1'b0;
                #1;
                check("abort_outputs", {cpu_rdy, dma_busy, dma_done, mem_address, mem_read_write},
                      {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
                check("abort_no_done", 64'(dones), 64'd0);
                return;
            end
        end
        exp_stall = 513 + ((ODD && halt_par) ? 1 : 0);
        check("finished", {63'h0, finished}, 64'd1);
        check("stall_len", 64'(stall), 64'(exp_stall));
        check("write_count", 64'(writes), 64'd256);
        check("done_pulses", 64'(dones), 64'd1);
        check("read_page", {63'h0, bad_addr}, 64'd0);
        if (retrig) begin
            @(negedge clk_in);
            #1;
            check("no_restart", {dma_busy, cpu_rdy}, {1'b0, 1'b1});
        end
    endtask

    initial begin
        int bad;
        reset = 1'b0; cpu_address = 16'h0000; cpu_data_out = 8'h00; cpu_read_write = 1'b0;
        vecs[0] = '{16'h0200, 8'hA5, 1'b1, 16'h0200, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 8'h3C, 1'b0, 16'h1234, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h4014, 8'h11, 1'b0, 16'h4014, 8'h11, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h4015, 8'h22, 1'b1, 16'h4015, 8'h22, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h2004, 8'hFF, 1'b1, 16'h2004, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h4013, 8'h00, 1'b1, 16'h4013, 8'h00, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk_in);
        cpu_address = 16'hBEEF; cpu_data_out = 8'h5A; cpu_read_write = 1'b1;
        #1;
        check("reset_state", {cpu_rdy, dma_busy, dma_done, mem_address, mem_data_out, mem_read_write},
              {1'b1, 1'b0, 1'b0, 16'hBEEF, 8'h5A, 1'b1});
        cpu_read_write = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            cpu_address = vecs[i].addr; cpu_data_out = vecs[i].data; cpu_read_write = vecs[i].rw;
            #1;
            check($sformatf("idle_vec%0d", i),
                  {mem_address, mem_data_out, mem_read_write, cpu_rdy, dma_busy},
                  {vecs[i].e_addr, vecs[i].e_data, vecs[i].e_rw, vecs[i].e_rdy, vecs[i].e_busy});
        end
        @(negedge clk_in);
        cpu_address = 16'h0000; cpu_data_out = 8'h00; cpu_read_write = 1'b0;
        #1;
        check("idle_no_trigger", {dma_busy, cpu_rdy}, {1'b0, 1'b1});
        check("idle_write_landed", {56'h0, mem[16'h0200]}, 64'hA5);

        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + 16'(i)] = 8'(i);
            mem[16'hFF00 + 16'(i)] = ~8'(i);
        end
        mem[16'h0000] = 8'hEE;

        // Trigger-cycle parity 1 -> HALT parity 0; the page FF run uses the opposite.
        wait_parity(1'b1);
        run_transfer(8'h02, 1'b1, 0);
        @(negedge clk_in);
        wait_parity(1'b0);
        run_transfer(8'hFF, 1'b0, 0);

        @(negedge clk_in);
        run_transfer(8'h02, 1'b0, 100);
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            #1;
            if (dma_done || dma_busy || !cpu_rdy || (mem_read_write && mem_address == DST)) bad++;
        end
        check("post_abort_idle", 64'(bad), 64'd0);
        run_transfer(8'h02, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
